// File: rtl/cause_control_mux.sv
// Exception cause selector: combinational 3-way mux plus an optional capture
// register that also records whether a capture used the reserved select code.
module cause_control_mux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] entry0,
    input  logic [WIDTH-1:0] entry1,
    input  logic [WIDTH-1:0] entry2,
    input  logic [1:0]       controlSingal,
    input  logic             causeWrite,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] causeReg,
    output logic             selInvalid
);

    logic sel_reserved;

    // Code 2'b11 and any unknown select bits fall through to zero.
    always_comb begin
        out = '0;
        case (controlSingal)
            2'b00:   out = entry0;
            2'b01:   out = entry1;
            2'b10:   out = entry2;
            default: out = '0;
        endcase
    end

    assign sel_reserved = (controlSingal == 2'b11);

    // selInvalid is sticky: only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            causeReg   <= '0;
            selInvalid <= 1'b0;
        end else if (causeWrite) begin
            causeReg <= out;
            if (sel_reserved)
                selInvalid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cause_control_mux.sv
// Directed bench for cause_control_mux: combinational select, capture,
// hold, sticky invalid flag, reset priority and back-to-back captures.
`timescale 1ns/1ps
module tb_cause_control_mux;

    localparam int WIDTH = 8;

    logic             clk;
    logic             clk_en;
    logic             reset;
    logic [WIDTH-1:0] entry0, entry1, entry2;
    logic [1:0]       controlSingal;
    logic             causeWrite;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] causeReg;
    logic             selInvalid;

    int n_checks;
    int n_fail;

    cause_control_mux #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .entry0       (entry0),
        .entry1       (entry1),
        .entry2       (entry2),
        .controlSingal(controlSingal),
        .causeWrite   (causeWrite),
        .out          (out),
        .causeReg     (causeReg),
        .selInvalid   (selInvalid)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_comb();
        logic [1:0]       sel_v [5];
        logic [WIDTH-1:0] exp_v [5];
        sel_v = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11};
        exp_v = '{8'hFF, 8'h0F, 8'h01, 8'hFF, 8'h00};
        clk_en = 1'b0;
        entry0 = 8'hFF; entry1 = 8'h0F; entry2 = 8'h01;
        for (int i = 0; i < 5; i++) begin
            controlSingal = sel_v[i];
            #1;
            n_checks++;
            if (out !== exp_v[i]) begin
                n_fail++;
                $display("FAIL comb_sel%0d: out=%h expected %h", i, out, exp_v[i]);
            end
            #10us;
        end
        // Reset must not touch the combinational path.
        controlSingal = 2'b01;
        reset = 1'b1;
        #1;
        n_checks++;
        if (out !== 8'h0F) begin
            n_fail++;
            $display("FAIL comb_during_reset: out=%h expected 0f", out);
        end
        clk_en = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; causeWrite = 1'b0;
        tick();
        n_checks++;
        if (causeReg !== 8'h00 || selInvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: causeReg=%h selInvalid=%b expected 00/0", causeReg, selInvalid);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (causeReg !== 8'h00 || selInvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: causeReg=%h selInvalid=%b expected 00/0", causeReg, selInvalid);
        end
    endtask

    task automatic test_capture();
        controlSingal = 2'b01; causeWrite = 1'b1;
        tick();
        n_checks++;
        if (causeReg !== 8'h0F || selInvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_sel01: causeReg=%h selInvalid=%b expected 0f/0", causeReg, selInvalid);
        end
    endtask

    task automatic test_hold();
        causeWrite = 1'b0; controlSingal = 2'b10;
        #1;
        n_checks++;
        if (out !== 8'h01 || causeReg !== 8'h0F) begin
            n_fail++;
            $display("FAIL hold_pre_edge: out=%h causeReg=%h expected 01/0f", out, causeReg);
        end
        tick();
        tick();
        n_checks++;
        if (causeReg !== 8'h0F) begin
            n_fail++;
            $display("FAIL hold_after_edges: causeReg=%h expected 0f", causeReg);
        end
    endtask

    task automatic test_invalid_sticky();
        causeWrite = 1'b1; controlSingal = 2'b11;
        tick();
        n_checks++;
        if (causeReg !== 8'h00 || selInvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL capture_sel11: causeReg=%h selInvalid=%b expected 00/1", causeReg, selInvalid);
        end
        controlSingal = 2'b00;
        tick();
        n_checks++;
        if (causeReg !== 8'hFF || selInvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_after_valid: causeReg=%h selInvalid=%b expected ff/1", causeReg, selInvalid);
        end
        causeWrite = 1'b0;
        tick();
        n_checks++;
        if (selInvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_idle: selInvalid=%b expected 1", selInvalid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (causeReg !== 8'h00 || selInvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clears: causeReg=%h selInvalid=%b expected 00/0", causeReg, selInvalid);
        end
    endtask

    task automatic test_reset_priority();
        // Load something nonzero first so a lost reset would be visible.
        causeWrite = 1'b1; controlSingal = 2'b01;
        tick();
        controlSingal = 2'b11;
        tick();
        reset = 1'b1; controlSingal = 2'b00;
        tick();
        n_checks++;
        if (causeReg !== 8'h00 || selInvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: causeReg=%h selInvalid=%b expected 00/0", causeReg, selInvalid);
        end
        reset = 1'b0; causeWrite = 1'b0;
        tick();
        n_checks++;
        if (causeReg !== 8'h00) begin
            n_fail++;
            $display("FAIL deassert_no_capture: causeReg=%h expected 00", causeReg);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]       sel_v [4];
        logic [WIDTH-1:0] e0_v  [4];
        logic [WIDTH-1:0] exp_v [4];
        sel_v = '{2'b00, 2'b01, 2'b10, 2'b00};
        e0_v  = '{8'hA5, 8'h11, 8'h22, 8'h3C};
        exp_v = '{8'hA5, 8'h0F, 8'h01, 8'h3C};
        causeWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            entry0 = e0_v[i];
            controlSingal = sel_v[i];
            tick();
            n_checks++;
            if (causeReg !== exp_v[i] || selInvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_%0d: causeReg=%h selInvalid=%b expected %h/0", i, causeReg, selInvalid, exp_v[i]);
            end
        end
        // Select wiggle between edges must not reach the register.
        causeWrite = 1'b0;
        controlSingal = 2'b01;
        #2;
        controlSingal = 2'b10;
        #1;
        n_checks++;
        if (causeReg !== 8'h3C || out !== 8'h01) begin
            n_fail++;
            $display("FAIL mid_cycle_sel: causeReg=%h out=%h expected 3c/01", causeReg, out);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        clk_en = 1'b0; reset = 1'b1; causeWrite = 1'b0;
        entry0 = '0; entry1 = '0; entry2 = '0; controlSingal = 2'b00;
        test_comb();
        test_reset();
        test_capture();
        test_hold();
        test_invalid_sticky();
        test_reset_priority();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
